instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 91 +++++++++
 tb/tb_instruction_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: reads a 1- or 2-byte instruction from ROM,
// strobes the instruction register halves and advances the program counter.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        len2,
  input  logic [7:0]  rom_byte,
  output logic [15:0] rom_addr,
  output logic        rom_rd,
  output logic        ir_load_high,
  output logic        ir_load_low,
  output logic        fetch_done,
  output logic        busy,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OPC_RD  = 3'd1,
    OPC_CAP = 3'd2,
    OPD_RD  = 3'd3,
    OPD_CAP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;

  // rom_byte is consumed by the external instruction register, not here.
  logic unused_rom_byte;
  assign unused_rom_byte = ^rom_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Jumps and new fetches are only accepted while idle; the 16-bit add wraps.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (pc_load) pc_d = pc_load_value;
        if (fetch_start) state_d = OPC_RD;
      end
      OPC_RD:  state_d = OPC_CAP;
      OPC_CAP: begin
        pc_d    = pc_q + 16'd1;
        state_d = len2 ? OPD_RD : DONE;
      end
      OPD_RD:  state_d = OPD_CAP;
      OPD_CAP: begin
        pc_d    = pc_q + 16'd1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rom_rd       = 1'b0;
    ir_load_high = 1'b0;
    ir_load_low  = 1'b0;
    fetch_done   = 1'b0;
    case (state_q)
      OPC_RD:  rom_rd       = 1'b1;
      OPC_CAP: ir_load_high = 1'b1;
      OPD_RD:  rom_rd       = 1'b1;
      OPD_CAP: ir_load_low  = 1'b1;
      DONE:    fetch_done   = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign pc       = pc_q;
  assign rom_addr = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small registered ROM model.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic        len2 = 1'b0;
  logic [7:0]  rom_byte = 8'h00;
  logic [15:0] rom_addr;
  logic        rom_rd;
  logic        ir_load_high;
  logic        ir_load_low;
  logic        fetch_done;
  logic        busy;
  logic [15:0] pc;

  int tests = 0;
  int fails = 0;
  int done_cnt;
  int low_cnt;

  instruction_fetch #(.RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .fetch_start(fetch_start),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .len2(len2),
    .rom_byte(rom_byte), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .ir_load_high(ir_load_high), .ir_load_low(ir_load_low),
    .fetch_done(fetch_done), .busy(busy), .pc(pc)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rom_read(input logic [15:0] a);
    case (a)
      16'h0000: rom_read = 8'h74;
      16'h0001: rom_read = 8'h3C;
      16'h0010: rom_read = 8'h04;
      16'h0123: rom_read = 8'h11;
      16'hFFFF: rom_read = 8'h9A;
      16'h0040: rom_read = 8'h55;
      16'h0041: rom_read = 8'h66;
      default:  rom_read = 8'hEE;
    endcase
  endfunction

  always @(posedge clock) if (rom_rd) rom_byte <= rom_read(rom_addr);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe vector: {rom_rd, ir_load_high, ir_load_low, fetch_done, busy}
  function automatic logic [31:0] strb();
    strb = {27'd0, rom_rd, ir_load_high, ir_load_low, fetch_done, busy};
  endfunction

  initial begin
    // Reset overrides simultaneous fetch_start and pc_load
    reset = 1'b1; fetch_start = 1'b1; pc_load = 1'b1; pc_load_value = 16'hABCD;
    tick(); tick();
    chk("rst_strobes", strb(), 32'b00000);
    chk("rst_pc", pc, 16'h0000);
    reset = 1'b0; fetch_start = 1'b0; pc_load = 1'b0;
    tick();
    chk("idle_hold", strb(), 32'b00000);

    // 2-byte fetch from 0000
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("a_c1_strb", strb(), 32'b10001);
    chk("a_c1_addr", rom_addr, 16'h0000);
    tick();
    len2 = 1'b1;
    chk("a_c2_strb", strb(), 32'b01001);
    chk("a_c2_byte", rom_byte, 8'h74);
    tick();
    len2 = 1'b0;
    chk("a_c3_strb", strb(), 32'b10001);
    chk("a_c3_addr", rom_addr, 16'h0001);
    tick();
    chk("a_c4_strb", strb(), 32'b00101);
    chk("a_c4_byte", rom_byte, 8'h3C);
    tick();
    chk("a_c5_strb", strb(), 32'b00011);
    chk("a_c5_pc", pc, 16'h0002);
    tick();
    chk("a_c6_strb", strb(), 32'b00000);

    // 1-byte fetch from 0010
    pc_load = 1'b1; pc_load_value = 16'h0010;
    tick();
    pc_load = 1'b0;
    chk("b_load_pc", pc, 16'h0010);
    chk("b_load_idle", strb(), 32'b00000);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("b_c1_addr", rom_addr, 16'h0010);
    tick();
    len2 = 1'b0;
    chk("b_c2_strb", strb(), 32'b01001);
    chk("b_c2_byte", rom_byte, 8'h04);
    tick();
    chk("b_c3_strb", strb(), 32'b00011);
    chk("b_c3_pc", pc, 16'h0011);
    tick();

    // Jump together with fetch_start
    pc_load = 1'b1; pc_load_value = 16'h0123; fetch_start = 1'b1;
    tick();
    pc_load = 1'b0; fetch_start = 1'b0;
    chk("c_c1_strb", strb(), 32'b10001);
    chk("c_c1_addr", rom_addr, 16'h0123);
    tick();
    chk("c_c2_byte", rom_byte, 8'h11);
    tick();
    chk("c_c3_strb", strb(), 32'b00011);
    chk("c_c3_pc", pc, 16'h0124);
    tick();

    // Wrap: 2-byte fetch at FFFF
    pc_load = 1'b1; pc_load_value = 16'hFFFF; fetch_start = 1'b1;
    tick();
    pc_load = 1'b0; fetch_start = 1'b0;
    chk("d_c1_addr", rom_addr, 16'hFFFF);
    tick();
    len2 = 1'b1;
    chk("d_c2_byte", rom_byte, 8'h9A);
    tick();
    len2 = 1'b0;
    chk("d_c3_strb", strb(), 32'b10001);
    chk("d_c3_addr", rom_addr, 16'h0000);
    tick();
    chk("d_c4_byte", rom_byte, 8'h74);
    tick();
    chk("d_c5_strb", strb(), 32'b00011);
    chk("d_c5_pc", pc, 16'h0001);
    tick();

    // fetch_start and pc_load pulsed in OPC_CAP are ignored
    pc_load = 1'b1; pc_load_value = 16'h0040; fetch_start = 1'b1;
    tick();
    pc_load = 1'b0; fetch_start = 1'b0;
    tick();
    chk("e_c2_strb", strb(), 32'b01001);
    len2 = 1'b1; fetch_start = 1'b1; pc_load = 1'b1; pc_load_value = 16'hBEEF;
    tick();
    len2 = 1'b0; fetch_start = 1'b0; pc_load = 1'b0;
    chk("e_c3_addr", rom_addr, 16'h0041);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (fetch_done) done_cnt++;
      tick();
    end
    chk("e_done_cnt", done_cnt, 1);
    chk("e_pc", pc, 16'h0042);
    chk("e_idle", strb(), 32'b00000);

    // Reset in OPD_RD aborts the fetch
    pc_load = 1'b1; pc_load_value = 16'h0200; fetch_start = 1'b1;
    tick();
    pc_load = 1'b0; fetch_start = 1'b0;
    tick();
    len2 = 1'b1;
    tick();
    len2 = 1'b0;
    chk("f_opd_rd", strb(), 32'b10001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("f_rst_strb", strb(), 32'b00000);
    chk("f_rst_pc", pc, 16'h0000);
    done_cnt = 0;
    low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (fetch_done) done_cnt++;
      if (ir_load_low) low_cnt++;
      tick();
    end
    chk("f_no_done", done_cnt, 0);
    chk("f_no_low", low_cnt, 0);
    chk("f_idle_pc", pc, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
